// File: rtl/plic_target.sv
// PLIC per-target back end: threshold qualify, claim/complete handshake.
// Define PLIC_TARGET_INPUT_REG_EN for an extra input register stage.
module plic_target #(
  parameter int SOURCES       = 16,
  parameter int PRIORITIES    = 7,
  parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PRIORITY_BITS-1:0] priority_i,
  input  logic [SOURCES_BITS-1:0]  id_i,
  input  logic [PRIORITY_BITS-1:0] threshold_i,
  input  logic                     claim_req_i,
  input  logic                     complete_req_i,
  input  logic [SOURCES_BITS-1:0]  complete_id_i,
  output logic                     ireq_o,
  output logic [SOURCES_BITS-1:0]  id_o,
  output logic                     claim_o,
  output logic [SOURCES_BITS-1:0]  claim_id_o,
  output logic                     complete_o,
  output logic [SOURCES_BITS-1:0]  complete_id_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    CLAIMED = 2'd2
  } state_t;

  state_t                   state;
  logic [PRIORITY_BITS-1:0] prio_r;
  logic [SOURCES_BITS-1:0]  id_r;
  logic [PRIORITY_BITS-1:0] prio_q;
  logic [SOURCES_BITS-1:0]  id_q;
  logic [SOURCES_BITS-1:0]  claimed_id;
  logic                     valid;
  logic                     claim_ok;
  logic                     done;

`ifdef PLIC_TARGET_INPUT_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_r <= '0;
      id_r   <= '0;
    end else begin
      prio_r <= priority_i;
      id_r   <= id_i;
    end
  end
`else
  assign prio_r = priority_i;
  assign id_r   = id_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= '0;
      id_q   <= '0;
    end else begin
      prio_q <= prio_r;
      id_q   <= id_r;
    end
  end

  // Threshold is live; only the tree result is pipelined.
  assign valid    = (prio_q > threshold_i) && (id_q != '0);
  assign claim_ok = claim_req_i && (state != CLAIMED) && valid;
  assign done     = complete_req_i && (state == CLAIMED)
                    && (complete_id_i == claimed_id);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      claimed_id    <= '0;
      ireq_o        <= 1'b0;
      id_o          <= '0;
      claim_o       <= 1'b0;
      claim_id_o    <= '0;
      complete_o    <= 1'b0;
      complete_id_o <= '0;
    end else begin
      ireq_o     <= valid && (state != CLAIMED) && !claim_ok;
      claim_o    <= claim_ok;
      complete_o <= done;
      if (claim_req_i) id_o <= claim_ok ? id_q : '0;
      if (claim_ok) begin
        claim_id_o <= id_q;
        claimed_id <= id_q;
      end
      if (done) complete_id_o <= complete_id_i;
      case (state)
        IDLE: begin
          if (claim_ok) state <= CLAIMED;
          else if (valid) state <= PEND;
        end
        PEND: begin
          if (claim_ok) state <= CLAIMED;
          else if (!valid) state <= IDLE;
        end
        CLAIMED: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
